// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the scoreboard hazard controller.
package hazard_pkg;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  localparam int CNT_BITS = 3;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  typedef enum logic {HZ_IDLE, HZ_FLUSH} hz_state_e;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register result-ready countdowns and rs1/rs2 busy lookup.
module hazard_scoreboard import hazard_pkg::*; #(
  parameter int LOAD_LAT = 1,
  parameter int ALU_LAT  = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              issue_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              rd_wren_i,
  input  logic              is_load_i,
  input  logic [REG_AW-1:0] rs1_addr_i,
  input  logic [REG_AW-1:0] rs2_addr_i,
  input  logic              is_rs2_i,
  output logic              busy_o
);
  logic [NUM_REGS-1:0][CNT_BITS-1:0] cnt_q, cnt_d;
  // x0 stays zero: the loop never writes entry 0
  always_comb begin
    cnt_d = '0;
    for (int r = 1; r < NUM_REGS; r++)
      cnt_d[r] = (issue_i && rd_wren_i && rd_addr_i == REG_AW'(r))
               ? (is_load_i ? CNT_BITS'(LOAD_LAT) : CNT_BITS'(ALU_LAT))
               : (cnt_q[r] != '0 ? cnt_q[r] - 1'b1 : '0);
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  assign busy_o = (rs1_addr_i != '0 && cnt_q[rs1_addr_i] != '0) ||
                  (is_rs2_i && rs2_addr_i != '0 && cnt_q[rs2_addr_i] != '0);
endmodule

// File: rtl/hazard_ctrl_sb.sv
// hazard_ctrl_sb: scoreboard stalls plus mispredict flush FSM for the 5-stage core.
// Define HAZARD_PERF_EN to add saturating stall/redirect counters.
module hazard_ctrl_sb import hazard_pkg::*; #(
  parameter int XLEN      = 32,
  parameter int LOAD_LAT  = 1,
  parameter int ALU_LAT   = 0,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            id_valid_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic            id_is_rs2_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic            id_rd_wren_i,
  input  logic            id_is_load_i,
  input  logic            ex_valid_i,
  input  logic            ex_is_ctrl_i,
  input  logic            ex_br_taken_i,
  input  logic            ex_pred_taken_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic [XLEN-1:0] ex_pred_target_i,
  output logic            pc_enable_o,
  output logic            id_enable_o,
  output logic            id_flush_o,
  output logic            ex_flush_o,
  output logic            restore_pc_o,
  output logic            stall_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] redirect_cnt_o
`endif
);
  localparam logic [1:0] FC_INIT = (FLUSH_CYC > 1) ? 2'(FLUSH_CYC - 2) : 2'd0;
  hz_state_e  state_q;
  logic [1:0] fcnt_q;
  logic mispred, in_flush, redirect, busy, issue;
  assign mispred = ex_valid_i && ex_is_ctrl_i &&
                   ((ex_br_taken_i != ex_pred_taken_i) ||
                    (ex_br_taken_i && ex_pred_taken_i && ex_target_i != ex_pred_target_i));
  assign in_flush     = state_q == HZ_FLUSH;
  assign redirect     = mispred && !in_flush;
  assign stall_o      = id_valid_i && !in_flush && !mispred && busy;
  assign id_flush_o   = redirect || in_flush;
  assign ex_flush_o   = id_flush_o || stall_o;
  assign restore_pc_o = redirect;
  assign pc_enable_o  = !stall_o;
  assign id_enable_o  = !stall_o;
  assign issue        = id_valid_i && !stall_o && !id_flush_o;
  hazard_scoreboard #(.LOAD_LAT(LOAD_LAT), .ALU_LAT(ALU_LAT)) u_sb (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .issue_i    (issue),
    .rd_addr_i  (id_rd_addr_i),
    .rd_wren_i  (id_rd_wren_i),
    .is_load_i  (id_is_load_i),
    .rs1_addr_i (id_rs1_addr_i),
    .rs2_addr_i (id_rs2_addr_i),
    .is_rs2_i   (id_is_rs2_i),
    .busy_o     (busy)
  );
  // redirect cycle itself is the first flush cycle; FLUSH covers the rest
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q <= HZ_IDLE;
      fcnt_q  <= '0;
    end else if (in_flush) begin
      state_q <= fcnt_q == '0 ? HZ_IDLE : HZ_FLUSH;
      fcnt_q  <= fcnt_q == '0 ? '0 : fcnt_q - 1'b1;
    end else if (redirect && FLUSH_CYC > 1) begin
      state_q <= HZ_FLUSH;
      fcnt_q  <= FC_INIT;
    end
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, redirect_cnt_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      stall_cnt_q    <= '0;
      redirect_cnt_q <= '0;
    end else begin
      if (stall_o && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + 1'b1;
      if (redirect && !(&redirect_cnt_q)) redirect_cnt_q <= redirect_cnt_q + 1'b1;
    end
  assign stall_cnt_o    = stall_cnt_q;
  assign redirect_cnt_o = redirect_cnt_q;
`endif
endmodule

// File: tb/tb_hazard_ctrl_sb.sv
// tb_hazard_ctrl_sb: two configurations (LOAD_LAT=1/FLUSH_CYC=1 and LOAD_LAT=3/ALU_LAT=1/FLUSH_CYC=3)
// driven in lockstep against a ready-time reference model.
module tb_hazard_ctrl_sb;
  typedef struct packed {
    logic idv; logic [4:0] rs1; logic [4:0] rs2; logic isrs2; logic [4:0] rd;
    logic wren; logic ld; logic exv; logic ctrl; logic tk; logic ptk;
    logic [31:0] tgt; logic [31:0] ptgt;
  } stim_t;
  localparam int LL [2] = '{1, 3};
  localparam int AL [2] = '{0, 1};
  localparam int FC [2] = '{1, 3};
  logic clk_i = 0, rst_i = 1;
  logic id_valid_i = 0, id_is_rs2_i = 0, id_rd_wren_i = 0, id_is_load_i = 0;
  logic [4:0] id_rs1_addr_i = 0, id_rs2_addr_i = 0, id_rd_addr_i = 0;
  logic ex_valid_i = 0, ex_is_ctrl_i = 0, ex_br_taken_i = 0, ex_pred_taken_i = 0;
  logic [31:0] ex_target_i = 0, ex_pred_target_i = 0;
  logic a_pc, a_id, a_idf, a_exf, a_rp, a_st, b_pc, b_id, b_idf, b_exf, b_rp, b_st;
  logic [5:0] a_o, b_o;
  assign a_o = {a_pc, a_id, a_idf, a_exf, a_rp, a_st};
  assign b_o = {b_pc, b_id, b_idf, b_exf, b_rp, b_st};
`ifdef HAZARD_PERF_EN
  logic [31:0] a_sc, a_rc, b_sc, b_rc;
`endif
  int chk = 0, err = 0;
  logic [11:0] exp_q[$];
  int unsigned ready_at [2][32];
  int unsigned cyc = 0;
  int fl_rem [2];
  int perf_st [2], perf_rd [2];
  always #5 clk_i = ~clk_i;

  hazard_ctrl_sb #(.XLEN(32), .LOAD_LAT(1), .ALU_LAT(0), .FLUSH_CYC(1), .CNT_W(32)) dut_a (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_is_rs2_i(id_is_rs2_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rd_wren_i(id_rd_wren_i), .id_is_load_i(id_is_load_i), .ex_valid_i(ex_valid_i),
    .ex_is_ctrl_i(ex_is_ctrl_i), .ex_br_taken_i(ex_br_taken_i), .ex_pred_taken_i(ex_pred_taken_i),
    .ex_target_i(ex_target_i), .ex_pred_target_i(ex_pred_target_i),
    .pc_enable_o(a_pc), .id_enable_o(a_id), .id_flush_o(a_idf), .ex_flush_o(a_exf),
    .restore_pc_o(a_rp), .stall_o(a_st)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(a_sc), .redirect_cnt_o(a_rc)
`endif
  );
  hazard_ctrl_sb #(.XLEN(32), .LOAD_LAT(3), .ALU_LAT(1), .FLUSH_CYC(3), .CNT_W(32)) dut_b (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_rs1_addr_i(id_rs1_addr_i),
    .id_rs2_addr_i(id_rs2_addr_i), .id_is_rs2_i(id_is_rs2_i), .id_rd_addr_i(id_rd_addr_i),
    .id_rd_wren_i(id_rd_wren_i), .id_is_load_i(id_is_load_i), .ex_valid_i(ex_valid_i),
    .ex_is_ctrl_i(ex_is_ctrl_i), .ex_br_taken_i(ex_br_taken_i), .ex_pred_taken_i(ex_pred_taken_i),
    .ex_target_i(ex_target_i), .ex_pred_target_i(ex_pred_target_i),
    .pc_enable_o(b_pc), .id_enable_o(b_id), .id_flush_o(b_idf), .ex_flush_o(b_exf),
    .restore_pc_o(b_rp), .stall_o(b_st)
`ifdef HAZARD_PERF_EN
    , .stall_cnt_o(b_sc), .redirect_cnt_o(b_rc)
`endif
  );

  function automatic stim_t id_op(logic [4:0] rs1, logic [4:0] rs2, logic isrs2, logic [4:0] rd,
                                  logic wren, logic ld);
    stim_t s = '0;
    s.idv = 1; s.rs1 = rs1; s.rs2 = rs2; s.isrs2 = isrs2; s.rd = rd; s.wren = wren; s.ld = ld;
    return s;
  endfunction
  function automatic stim_t br(logic tk, logic ptk, logic [31:0] tgt, logic [31:0] ptgt);
    stim_t s = '0;
    s.exv = 1; s.ctrl = 1; s.tk = tk; s.ptk = ptk; s.tgt = tgt; s.ptgt = ptgt;
    return s;
  endfunction

  // Reference model: remembers the cycle each register becomes ready; pushes both expectations.
  task automatic step();
    logic [11:0] e;
    logic mp, infl, redir, st, idfl, iss, bz1, bz2;
    mp = ex_valid_i & ex_is_ctrl_i & ((ex_br_taken_i != ex_pred_taken_i) |
         (ex_br_taken_i & ex_pred_taken_i & (ex_target_i != ex_pred_target_i)));
    for (int k = 0; k < 2; k++) begin
      infl  = fl_rem[k] > 0;
      redir = mp & ~infl;
      bz1   = id_rs1_addr_i != 0 && cyc < ready_at[k][id_rs1_addr_i];
      bz2   = id_is_rs2_i && id_rs2_addr_i != 0 && cyc < ready_at[k][id_rs2_addr_i];
      st    = id_valid_i & ~infl & ~mp & (bz1 | bz2);
      idfl  = redir | infl;
      iss   = id_valid_i & ~st & ~idfl;
      e[k*6 +: 6] = {~st, ~st, idfl, idfl | st, redir, st};
      if (infl) fl_rem[k]--;
      else if (redir) fl_rem[k] = FC[k] - 1;
      if (iss && id_rd_wren_i && id_rd_addr_i != 0)
        ready_at[k][id_rd_addr_i] = cyc + 1 + (id_is_load_i ? LL[k] : AL[k]);
      perf_st[k] += int'(st);
      perf_rd[k] += int'(redir);
    end
    cyc++;
    exp_q.push_back(e);
  endtask
  task automatic apply(input stim_t s);
    id_valid_i = s.idv; id_rs1_addr_i = s.rs1; id_rs2_addr_i = s.rs2; id_is_rs2_i = s.isrs2;
    id_rd_addr_i = s.rd; id_rd_wren_i = s.wren; id_is_load_i = s.ld;
    ex_valid_i = s.exv; ex_is_ctrl_i = s.ctrl; ex_br_taken_i = s.tk; ex_pred_taken_i = s.ptk;
    ex_target_i = s.tgt; ex_pred_target_i = s.ptgt;
    step();
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 32; r++) ready_at[k][r] = 0;
      fl_rem[k] = 0; perf_st[k] = 0; perf_rd[k] = 0;
    end
  endtask

  task automatic test_reset();
    #3;
    chk++;
    if ({b_o, a_o} !== 12'b110000_110000) begin
      err++; $display("FAIL reset got %b exp %b", {b_o, a_o}, 12'b110000_110000);
    end
`ifdef HAZARD_PERF_EN
    chk++;
    if ({a_sc, a_rc, b_sc, b_rc} !== '0) begin
      err++; $display("FAIL reset_perf got %h %h %h %h exp 0", a_sc, a_rc, b_sc, b_rc);
    end
`endif
    model_reset();
    @(negedge clk_i); rst_i = 0;
    @(posedge clk_i); #1;
  endtask

  task automatic test_load_use();
    stim_t seq[$];
    logic [11:0] e;
    int sa = 0, sb = 0;
    seq.push_back(id_op(1, 0, 0, 5, 1, 1));
    repeat (4) seq.push_back(id_op(5, 1, 1, 6, 1, 0));
    repeat (3) seq.push_back('0);
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk_i); e = exp_q.pop_front(); chk++;
      if ({b_o, a_o} !== e) begin err++; $display("FAIL load_use step %0d got %b exp %b", i, {b_o, a_o}, e); end
      if (i == 1) begin
        chk++;
        if (a_o !== 6'b000101) begin err++; $display("FAIL load_use_bubble got %b exp 000101", a_o); end
      end
      sa += int'(a_st); sb += int'(b_st);
      @(posedge clk_i); #1;
    end
    chk++;
    if (sa != 1 || sb != 3) begin err++; $display("FAIL load_use_len got %0d/%0d exp 1/3", sa, sb); end
  endtask

  task automatic test_x0_rs2();
    stim_t seq[$];
    logic [11:0] e;
    int sa = 0, sb = 0;
    seq.push_back(id_op(1, 0, 0, 0, 1, 1));
    repeat (2) seq.push_back(id_op(0, 0, 1, 3, 1, 0));
    seq.push_back(id_op(1, 0, 0, 9, 1, 1));
    repeat (2) seq.push_back(id_op(2, 9, 0, 4, 1, 0));
    repeat (3) seq.push_back('0);
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk_i); e = exp_q.pop_front(); chk++;
      if ({b_o, a_o} !== e) begin err++; $display("FAIL x0_rs2 step %0d got %b exp %b", i, {b_o, a_o}, e); end
      sa += int'(a_st); sb += int'(b_st);
      @(posedge clk_i); #1;
    end
    chk++;
    if (sa != 0 || sb != 0) begin err++; $display("FAIL x0_rs2_stalls got %0d/%0d exp 0/0", sa, sb); end
  endtask

  task automatic test_alu_lat();
    stim_t seq[$];
    logic [11:0] e;
    int sa = 0, sb = 0;
    seq.push_back(id_op(1, 0, 0, 7, 1, 0));
    repeat (2) seq.push_back(id_op(7, 0, 0, 8, 1, 0));
    repeat (2) seq.push_back('0);
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk_i); e = exp_q.pop_front(); chk++;
      if ({b_o, a_o} !== e) begin err++; $display("FAIL alu_lat step %0d got %b exp %b", i, {b_o, a_o}, e); end
      sa += int'(a_st); sb += int'(b_st);
      @(posedge clk_i); #1;
    end
    chk++;
    if (sa != 0 || sb != 1) begin err++; $display("FAIL alu_lat_stalls got %0d/%0d exp 0/1", sa, sb); end
  endtask

  task automatic test_mispred();
    stim_t seq[$];
    logic [11:0] e;
    int ra = 0, rb = 0, fa = 0, fb = 0;
    seq.push_back(br(1, 0, 32'h100, 32'h0));
    repeat (3) seq.push_back('0);
    repeat (3) seq.push_back(br(1, 0, 32'h100, 32'h0));
    repeat (3) seq.push_back('0);
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk_i); e = exp_q.pop_front(); chk++;
      if ({b_o, a_o} !== e) begin err++; $display("FAIL mispred step %0d got %b exp %b", i, {b_o, a_o}, e); end
      ra += int'(a_rp); rb += int'(b_rp); fa += int'(a_idf); fb += int'(b_idf);
      @(posedge clk_i); #1;
    end
    chk++;
    if (ra != 4 || rb != 2 || fa != 4 || fb != 6) begin
      err++; $display("FAIL mispred_counts got %0d/%0d/%0d/%0d exp 4/2/4/6", ra, rb, fa, fb);
    end
  endtask

  task automatic test_target();
    stim_t seq[$];
    stim_t s;
    logic [11:0] e;
    int ra = 0, rb = 0;
    seq.push_back(br(1, 1, 32'h200, 32'h204));
    repeat (3) seq.push_back('0);
    seq.push_back(br(1, 1, 32'h200, 32'h200));
    repeat (3) seq.push_back('0);
    seq.push_back(br(0, 1, 32'h0, 32'h300));
    repeat (3) seq.push_back('0);
    s = br(1, 0, 32'h100, 32'h0); s.ctrl = 0;
    seq.push_back(s);
    seq.push_back('0);
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk_i); e = exp_q.pop_front(); chk++;
      if ({b_o, a_o} !== e) begin err++; $display("FAIL target step %0d got %b exp %b", i, {b_o, a_o}, e); end
      ra += int'(a_rp); rb += int'(b_rp);
      @(posedge clk_i); #1;
    end
    chk++;
    if (ra != 2 || rb != 2) begin err++; $display("FAIL target_redirects got %0d/%0d exp 2/2", ra, rb); end
  endtask

  task automatic test_stall_vs_mispred();
    stim_t seq[$];
    stim_t s;
    logic [11:0] e;
    seq.push_back(id_op(1, 0, 0, 5, 1, 1));
    s = br(1, 0, 32'h100, 32'h0);
    s.idv = 1; s.rs1 = 5; s.rd = 6; s.wren = 1; s.ld = 1;
    seq.push_back(s);
    seq.push_back(id_op(6, 0, 0, 0, 0, 0));
    repeat (4) seq.push_back('0);
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk_i); e = exp_q.pop_front(); chk++;
      if ({b_o, a_o} !== e) begin err++; $display("FAIL stall_vs_mp step %0d got %b exp %b", i, {b_o, a_o}, e); end
      if (i == 1) begin
        chk++;
        if ({b_o, a_o} !== 12'b111110_111110) begin
          err++; $display("FAIL stall_vs_mp_prio got %b exp 111110111110", {b_o, a_o});
        end
      end
      if (i == 2) begin
        chk++;
        if (a_st !== 1'b0) begin err++; $display("FAIL stall_vs_mp_nowrite got %b exp 0", a_st); end
      end
      @(posedge clk_i); #1;
    end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    chk++;
    if (a_sc !== 32'(perf_st[0]) || a_rc !== 32'(perf_rd[0])) begin
      err++; $display("FAIL perf_a got %0d/%0d exp %0d/%0d", a_sc, a_rc, perf_st[0], perf_rd[0]);
    end
    chk++;
    if (b_sc !== 32'(perf_st[1]) || b_rc !== 32'(perf_rd[1])) begin
      err++; $display("FAIL perf_b got %0d/%0d exp %0d/%0d", b_sc, b_rc, perf_st[1], perf_rd[1]);
    end
  endtask
`endif

  task automatic test_reset_mid_flush();
    stim_t seq[$];
    logic [11:0] e;
    seq.push_back(id_op(1, 0, 0, 5, 1, 1));
    seq.push_back(br(1, 0, 32'h100, 32'h0));
    foreach (seq[i]) begin
      apply(seq[i]);
      @(negedge clk_i); e = exp_q.pop_front(); chk++;
      if ({b_o, a_o} !== e) begin err++; $display("FAIL rst_mid step %0d got %b exp %b", i, {b_o, a_o}, e); end
      @(posedge clk_i); #1;
    end
    apply(id_op(5, 0, 0, 0, 0, 0));
    @(negedge clk_i); e = exp_q.pop_front(); chk++;
    if ({b_o, a_o} !== e) begin err++; $display("FAIL rst_mid pre got %b exp %b", {b_o, a_o}, e); end
    chk++;
    if (b_o !== 6'b111100) begin err++; $display("FAIL rst_mid_inflush got %b exp 111100", b_o); end
    #1 rst_i = 1;
    #1;
    chk++;
    if ({b_o, a_o} !== 12'b110000_110000) begin
      err++; $display("FAIL rst_mid_async got %b exp 110000110000", {b_o, a_o});
    end
    model_reset();
    id_valid_i = 0; ex_valid_i = 0;
    @(posedge clk_i);
    @(negedge clk_i); rst_i = 0;
    @(posedge clk_i); #1;
    apply(id_op(5, 0, 0, 0, 0, 0));
    @(negedge clk_i); e = exp_q.pop_front(); chk++;
    if ({b_o, a_o} !== e) begin err++; $display("FAIL rst_mid post got %b exp %b", {b_o, a_o}, e); end
    chk++;
    if (b_o !== 6'b110000) begin err++; $display("FAIL rst_mid_cleared got %b exp 110000", b_o); end
    @(posedge clk_i); #1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0_rs2();
    test_alu_lat();
    test_mispred();
    test_target();
    test_stall_vs_mispred();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    test_reset_mid_flush();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end
endmodule
